wb_dma_arbiter: RTL and testbench
=================================

# wb_dma_arbiter

Round-robin arbiter that shares one 32-bit pipelined Wishbone master port between NUM_MASTERS requesters, for example the DMA burst FSM and a second DMA channel or debug master. A grant is held for the owner's whole CYC, so 4-word bursts and read-modify-write sequences are never interleaved. A per-grant watchdog aborts a cycle whose slave never acknowledges, so the shared bus cannot lock up.

## Interface
Parameters:
- NUM_MASTERS, 2, number of requesters; legal range 2..4.
- TIMEOUT_CYCLES, 1024, maximum cycles allowed without ACK/ERR while owned; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- m_adr_i  in  NUM_MASTERS*30  word address per master; master i occupies bits [i*30 +: 30].
- m_dat_i  in  NUM_MASTERS*32  write data per master.
- m_sel_i  in  NUM_MASTERS*4  byte selects per master.
- m_we_i, m_stb_i, m_cyc_i  in  NUM_MASTERS  per-master WE, STB and CYC.
- m_dat_o  out  32  read data, broadcast to all masters (= s_dat_i).
- m_ack_o, m_stall_o, m_err_o  out  NUM_MASTERS  per-master ACK, STALL and ERR.
- grant_o  out  NUM_MASTERS  one-hot current owner; all zeros when there is no owner.
- s_adr_o  out  30  shared slave address.
- s_dat_o  out  32  shared slave write data.
- s_sel_o  out  4  shared slave byte selects.
- s_we_o, s_stb_o, s_cyc_o  out  1  shared slave WE, STB and CYC.
- s_dat_i  in  32  slave read data.
- s_ack_i, s_stall_i, s_err_i  in  1  slave ACK, STALL and ERR.

## Operation
- FSM states: IDLE, OWNED, ABORT.
- IDLE:
  - No owner; s_cyc_o = s_stb_o = 0.
  - If any m_cyc_i is set, pick the winner: the first requester found scanning upward from last_grant+1 (mod NUM_MASTERS).
  - Register the winner's index as owner and go to OWNED.
- OWNED:
  - s_adr/dat/sel/we/stb/cyc_o follow the owner's inputs combinationally.
  - Owner's m_ack_o = s_ack_i, m_err_o = s_err_i, m_stall_o = s_stall_i.
  - Every non-owner sees m_stall_o = 1 and m_ack_o = m_err_o = 0.
  - Owner drops m_cyc_i: set last_grant to owner and go to IDLE.
- Watchdog, active in OWNED only:
  - Counter clears on entry to OWNED and on any cycle with s_ack_i or s_err_i.
  - Otherwise it increments every OWNED cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no ACK/ERR that cycle, go to ABORT.
- ABORT:
  - s_cyc_o = s_stb_o = 0.
  - Owner's m_err_o = 1 in the first ABORT cycle only; owner's m_stall_o = 1.
  - Stay until the owner drops m_cyc_i, then set last_grant to owner and go to IDLE.
- s_ack_i or s_err_i arriving in IDLE or ABORT (late response) is discarded and never forwarded.
- Reset values: state IDLE, owner none, last_grant = NUM_MASTERS-1 (master 0 wins first), counter 0.
  - Outputs under reset: grant_o = 0, s_cyc_o = s_stb_o = s_we_o = 0, s_adr_o/s_dat_o/s_sel_o = 0.
  - m_ack_o = m_err_o = 0; m_stall_o = all ones.

## Timing
- Arbitration latency is one cycle. A request raised in cycle T is granted at the edge ending T and first reaches the slave in T+1.
  - The master's STB is stalled during T, so it must hold its STB and request data until then.
- Release costs one dead IDLE cycle. The cycle after the owner drops CYC is IDLE; the next owner reaches the slave one cycle after that.
  - Back-to-back ownership therefore costs 2 cycles.
- ACK, ERR and STALL have zero added latency in OWNED (purely combinational path). s_dat_i reaches m_dat_o with zero latency in every state.
- Owner dropping CYC in the same cycle as s_ack_i: the ACK is forwarded, then the FSM goes to IDLE.
- A master holding CYC high without STB keeps ownership. The watchdog still runs, so an idle CYC hold aborts after TIMEOUT_CYCLES.
- Reset in any state: the next edge puts every output at its reset value, even mid-burst.

## Test plan
- Single master: master 0 writes 0xDEADBEEF to word address 0x100 with ack latency 2 -> s_* outputs match from cycle T+1; m_ack_o[0] pulses once; grant_o = 0b01 until CYC drops.
- Round-robin: masters 0 and 1 both request continuously with 4-beat bursts -> grants alternate 0,1,0,1; no beat of one burst is interleaved with the other; 2-cycle gap between owners.
- Lock: master 1 raises CYC while master 0 is mid-burst (beat 2 of 4) -> m_stall_o[1] stays 1 and master 1 gets no ack until master 0 completes all 4 beats and drops CYC.
- Timeout: TIMEOUT_CYCLES = 8, slave never acks -> s_cyc_o drops after 8 OWNED cycles; m_err_o pulses for exactly 1 cycle; a late s_ack_i is not forwarded; master 1 is granted after master 0 drops CYC.
- Slave error: s_err_i in OWNED -> forwarded to the owner in the same cycle; watchdog counter clears.
- Reset mid-burst: rst asserted in beat 2 -> next cycle grant_o = 0, s_cyc_o = 0, m_stall_o = all ones; after release, master 0 wins first.

Source files
------------

// File: rtl/wb_dma_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone master port among NUM_MASTERS
// requesters; ownership lasts a whole CYC, with a no-response watchdog per grant.
module wb_dma_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS*30-1:0] m_adr_i,
  input  logic [NUM_MASTERS*32-1:0] m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  output logic [31:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_stall_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic [29:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic                      s_stb_o,
  output logic                      s_cyc_o,
  input  logic [31:0]               s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_stall_i,
  input  logic                      s_err_i
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_OWNED, S_ABORT} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_last;
  logic [CW-1:0]   r_cnt;
  logic            r_abort_first;

  logic [NUM_MASTERS-1:0][29:0] w_adr;
  logic [NUM_MASTERS-1:0][31:0] w_dat;
  logic [NUM_MASTERS-1:0][3:0]  w_sel;
  logic [IW-1:0]                w_win;
  logic                         w_own_cyc;
  logic                         w_resp;

  assign w_adr     = m_adr_i;
  assign w_dat     = m_dat_i;
  assign w_sel     = m_sel_i;
  assign w_own_cyc = m_cyc_i[r_owner];
  assign w_resp    = s_ack_i | s_err_i;
  assign m_dat_o   = s_dat_i;

  // First requester found scanning upward from the slot after the last owner.
  always_comb begin
    logic          v_found;
    logic [IW-1:0] v_idx;
    w_win   = r_last;
    v_found = 1'b0;
    v_idx   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      v_idx = IW'((int'(r_last) + k) % NUM_MASTERS);
      if (!v_found && m_cyc_i[v_idx]) begin
        w_win   = v_idx;
        v_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_owner       <= '0;
      r_last        <= IW'(NUM_MASTERS - 1);
      r_cnt         <= '0;
      r_abort_first <= 1'b0;
    end else begin
      r_abort_first <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|m_cyc_i) begin
            r_owner <= w_win;
            r_cnt   <= '0;
            r_state <= S_OWNED;
          end
        end
        S_OWNED: begin
          if (!w_own_cyc) begin
            r_last  <= r_owner;
            r_state <= S_IDLE;
          end else if (w_resp) begin
            r_cnt <= '0;
          end else if (TIMEOUT_CYCLES != 0 && r_cnt == CNT_MAX) begin
            r_state       <= S_ABORT;
            r_abort_first <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ABORT: begin
          if (!w_own_cyc) begin
            r_last  <= r_owner;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Owner's bus and responses pass straight through; late responses outside OWNED are dropped.
  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_stb_o   = 1'b0;
    s_cyc_o   = 1'b0;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_stall_o = '1;
    grant_o   = '0;
    if (r_state != S_IDLE) grant_o[r_owner] = 1'b1;
    if (r_state == S_OWNED) begin
      s_adr_o            = w_adr[r_owner];
      s_dat_o            = w_dat[r_owner];
      s_sel_o            = w_sel[r_owner];
      s_we_o             = m_we_i[r_owner];
      s_stb_o            = m_stb_i[r_owner];
      s_cyc_o            = m_cyc_i[r_owner];
      m_ack_o[r_owner]   = s_ack_i;
      m_err_o[r_owner]   = s_err_i;
      m_stall_o[r_owner] = s_stall_i;
    end else if (r_state == S_ABORT) begin
      m_err_o[r_owner] = r_abort_first;
    end
  end

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Bench for wb_dma_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level ownership model.
module tb_wb_dma_arbiter;
  localparam int N  = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N*30-1:0]   m_adr_i;
  logic [N*32-1:0]   m_dat_i;
  logic [N*4-1:0]    m_sel_i;
  logic [N-1:0]      m_we_i, m_stb_i, m_cyc_i;
  logic [31:0]       m_dat_o;
  logic [N-1:0]      m_ack_o, m_stall_o, m_err_o, grant_o;
  logic [29:0]       s_adr_o;
  logic [31:0]       s_dat_o;
  logic [3:0]        s_sel_o;
  logic              s_we_o, s_stb_o, s_cyc_o;
  logic [31:0]       s_dat_i;
  logic              s_ack_i, s_stall_i, s_err_i;

  int checks   = 0;
  int failures = 0;

  wb_dma_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_stall_o(m_stall_o), .m_err_o(m_err_o),
    .grant_o(grant_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_stall_i(s_stall_i), .s_err_i(s_err_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    m_we_i = '0; m_stb_i = '0; m_cyc_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_stall_i = 1'b0; s_err_i = 1'b0;
  endtask

  task automatic drive_m(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [29:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    m_cyc_i[i] = cyc;
    m_stb_i[i] = stb;
    m_we_i[i]  = we;
    m_adr_i[i*30 +: 30] = adr;
    m_dat_i[i*32 +: 32] = dat;
    m_sel_i[i*4 +: 4]   = sel;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    drive_m(0, 1'b1, 1'b1, 1'b1, 30'h3ff, 32'hffff_ffff, 4'hf);
    s_ack_i = 1'b1; s_err_i = 1'b1; s_dat_i = 32'h1234_5678;
    tick(); tick();
    #4;
    checks++;
    if ({grant_o, s_cyc_o, s_stb_o, s_we_o} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got grant=%b cyc=%b stb=%b we=%b exp all 0", grant_o, s_cyc_o, s_stb_o, s_we_o);
    end
    checks++;
    if ({s_adr_o, s_dat_o, s_sel_o} !== '0) begin
      failures++;
      $display("FAIL reset_bus got adr=%h dat=%h sel=%h exp 0", s_adr_o, s_dat_o, s_sel_o);
    end
    checks++;
    if (m_ack_o !== '0 || m_err_o !== '0 || m_stall_o !== '1) begin
      failures++;
      $display("FAIL reset_resp got ack=%b err=%b stall=%b exp 000/000/111", m_ack_o, m_err_o, m_stall_o);
    end
    checks++;
    if (m_dat_o !== 32'h1234_5678) begin
      failures++;
      $display("FAIL reset_rdata got %h exp 12345678", m_dat_o);
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_single();
    int ackcnt = 0;
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b1, 30'h100, 32'hDEADBEEF, 4'hf);
    #4;
    checks++;
    if (m_stall_o[0] !== 1'b1 || s_cyc_o !== 1'b0 || grant_o !== '0) begin
      failures++;
      $display("FAIL single_req got stall0=%b s_cyc=%b grant=%b exp 1/0/000", m_stall_o[0], s_cyc_o, grant_o);
    end
    tick(); #4;
    checks++;
    if ({grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o} !==
        {3'b001, 1'b1, 1'b1, 1'b1, 30'h100, 32'hDEADBEEF, 4'hf}) begin
      failures++;
      $display("FAIL single_bus got grant=%b cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h exp 001/1/1/1/100/deadbeef/f",
               grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o);
    end
    checks++;
    if (m_stall_o !== 3'b110) begin
      failures++;
      $display("FAIL single_stall got %b exp 110", m_stall_o);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 0) m_stb_i[0] = 1'b0;
      s_ack_i = (k == 1);
      if (k == 2) m_cyc_i[0] = 1'b0;
      #4;
      ackcnt += int'(m_ack_o[0]);
      checks++;
      if (grant_o !== 3'b001) begin
        failures++;
        $display("FAIL single_hold k=%0d got grant=%b exp 001", k, grant_o);
      end
    end
    checks++;
    if (ackcnt != 1) begin
      failures++;
      $display("FAIL single_ackcnt got %0d exp 1", ackcnt);
    end
    tick(); #4;
    checks++;
    if (grant_o !== '0 || s_cyc_o !== 1'b0) begin
      failures++;
      $display("FAIL single_release got grant=%b cyc=%b exp 000/0", grant_o, s_cyc_o);
    end
  endtask

  task automatic test_round_robin();
    int issued[2], acked[2];
    bit drop[2];
    logic ack_pend = 1'b0;
    int seq[$];
    logic [N-1:0] prev_g = '0;
    int zero_run = 0, gap_bad = 0, order_bad = 0, g;
    issued = '{0, 0}; acked = '{0, 0}; drop = '{0, 0};
    do_reset();
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < 2; i++)
        drive_m(i, !drop[i], !drop[i] && issued[i] < 4, 1'b1, 30'(i*16 + issued[i]), 32'(i), 4'hf);
      s_ack_i = ack_pend;
      #4;
      checks++;
      if ((m_ack_o & ~grant_o) !== '0 || (m_stall_o | grant_o) !== '1) begin
        failures++;
        $display("FAIL rr_nonowner c=%0d ack=%b stall=%b grant=%b", c, m_ack_o, m_stall_o, grant_o);
      end
      g = grant_o[1] ? 1 : (grant_o[2] ? 2 : 0);
      if (grant_o !== '0) begin
        checks++;
        if (s_adr_o[29:4] !== 26'(g)) begin
          failures++;
          $display("FAIL rr_interleave c=%0d adr=%h owner=%0d", c, s_adr_o, g);
        end
      end
      if (grant_o !== prev_g) begin
        if (grant_o !== '0) begin
          seq.push_back(g);
          if (prev_g !== '0 || (seq.size() > 1 && zero_run != 1)) gap_bad++;
        end
      end
      zero_run = (grant_o === '0) ? zero_run + 1 : 0;
      prev_g = grant_o;
      ack_pend = s_cyc_o & s_stb_o;
      for (int i = 0; i < 2; i++) begin
        acked[i] += int'(m_ack_o[i]);
        if (drop[i]) drop[i] = 1'b0;
        else if (m_stb_i[i] && !m_stall_o[i]) issued[i]++;
        if (acked[i] == 4) begin
          drop[i] = 1'b1; acked[i] = 0; issued[i] = 0;
        end
      end
      tick();
    end
    foreach (seq[j]) if (seq[j] != j % 2) order_bad++;
    checks++;
    if (seq.size() < 6 || order_bad != 0) begin
      failures++;
      $display("FAIL rr_order grants=%0d out_of_order=%0d exp >=6 alternating from 0", seq.size(), order_bad);
    end
    checks++;
    if (gap_bad != 0) begin
      failures++;
      $display("FAIL rr_gap bad_gaps=%0d exp 0 (one idle cycle between owners)", gap_bad);
    end
  endtask

  task automatic test_lock();
    int acks0 = 0;
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 30'h200, 32'h0, 4'hf);
    for (int k = 0; k < 5; k++) begin
      tick();
      drive_m(0, 1'b1, k < 4, 1'b0, 30'(k + 'h200), 32'h0, 4'hf);
      s_ack_i = (k >= 1);
      if (k == 1) drive_m(1, 1'b1, 1'b1, 1'b0, 30'h300, 32'h0, 4'hf);
      #4;
      acks0 += int'(m_ack_o[0]);
      checks++;
      if (k >= 1 && (m_stall_o[1] !== 1'b1 || m_ack_o[1] !== 1'b0 || grant_o !== 3'b001)) begin
        failures++;
        $display("FAIL lock_hold k=%0d stall1=%b ack1=%b grant=%b exp 1/0/001", k, m_stall_o[1], m_ack_o[1], grant_o);
      end
    end
    tick();
    m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0; s_ack_i = 1'b0;
    #4;
    checks++;
    if (grant_o !== 3'b001 || m_stall_o[1] !== 1'b1) begin
      failures++;
      $display("FAIL lock_drop grant=%b stall1=%b exp 001/1", grant_o, m_stall_o[1]);
    end
    tick(); #4;
    checks++;
    if (grant_o !== '0 || m_stall_o[1] !== 1'b1) begin
      failures++;
      $display("FAIL lock_idle grant=%b stall1=%b exp 000/1", grant_o, m_stall_o[1]);
    end
    tick(); #4;
    checks++;
    if (grant_o !== 3'b010 || m_stall_o[1] !== 1'b0 || s_adr_o !== 30'h300) begin
      failures++;
      $display("FAIL lock_next grant=%b stall1=%b adr=%h exp 010/0/300", grant_o, m_stall_o[1], s_adr_o);
    end
    checks++;
    if (acks0 != 4) begin
      failures++;
      $display("FAIL lock_acks0 got %0d exp 4", acks0);
    end
  endtask

  task automatic test_timeout();
    int cyc_cnt = 0, errs = 0;
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b1, 30'h55, 32'h55, 4'hf);
    for (int k = 0; k < TO; k++) begin
      tick();
      if (k == 2) drive_m(1, 1'b1, 1'b1, 1'b0, 30'h66, 32'h0, 4'hf);
      #4;
      cyc_cnt += int'(s_cyc_o);
      errs += int'(m_err_o[0]);
    end
    checks++;
    if (cyc_cnt != TO || errs != 0) begin
      failures++;
      $display("FAIL to_owned cyc_cycles=%0d errs=%0d exp %0d/0", cyc_cnt, errs, TO);
    end
    tick(); #4;
    checks++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m_err_o !== 3'b001 || grant_o !== 3'b001) begin
      failures++;
      $display("FAIL to_abort cyc=%b stb=%b err=%b grant=%b exp 0/0/001/001", s_cyc_o, s_stb_o, m_err_o, grant_o);
    end
    tick();
    s_ack_i = 1'b1;
    #4;
    checks++;
    if (m_ack_o !== '0 || m_err_o !== '0 || s_cyc_o !== 1'b0) begin
      failures++;
      $display("FAIL to_late_ack ack=%b err=%b cyc=%b exp 000/000/0", m_ack_o, m_err_o, s_cyc_o);
    end
    tick();
    s_ack_i = 1'b0; m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
    #4;
    checks++;
    if (grant_o !== 3'b001 || m_err_o !== '0) begin
      failures++;
      $display("FAIL to_drop grant=%b err=%b exp 001/000", grant_o, m_err_o);
    end
    tick(); #4;
    checks++;
    if (grant_o !== '0) begin
      failures++;
      $display("FAIL to_idle grant=%b exp 000", grant_o);
    end
    tick(); #4;
    checks++;
    if (grant_o !== 3'b010 || s_cyc_o !== 1'b1) begin
      failures++;
      $display("FAIL to_next grant=%b cyc=%b exp 010/1", grant_o, s_cyc_o);
    end
  endtask

  task automatic test_slave_err();
    do_reset();
    drive_m(0, 1'b1, 1'b0, 1'b0, 30'h77, 32'h0, 4'h1);
    for (int c = 0; c <= 14; c++) begin
      tick();
      s_err_i = (c == 5);
      #4;
      if (c == 5) begin
        checks++;
        if (m_err_o !== 3'b001) begin
          failures++;
          $display("FAIL err_fwd got %b exp 001", m_err_o);
        end
      end
      checks++;
      if (s_cyc_o !== (c != 14) || (c == 14 && m_err_o !== 3'b001)) begin
        failures++;
        $display("FAIL err_wd c=%0d cyc=%b err=%b exp cyc=%b", c, s_cyc_o, m_err_o, c != 14);
      end
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    drive_m(0, 1'b1, 1'b1, 1'b0, 30'h10, 32'h0, 4'hf);
    tick();
    m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
    drive_m(1, 1'b1, 1'b1, 1'b1, 30'h20, 32'h2, 4'hf);
    tick();
    tick();
    s_ack_i = 1'b1;
    drive_m(1, 1'b1, 1'b1, 1'b1, 30'h21, 32'h3, 4'hf);
    tick();
    rst = 1'b1;
    drive_m(0, 1'b1, 1'b1, 1'b0, 30'h11, 32'h0, 4'hf);
    #4;
    checks++;
    if (grant_o !== 3'b010 || m_ack_o !== 3'b010) begin
      failures++;
      $display("FAIL rstmb_pre grant=%b ack=%b exp 010/010", grant_o, m_ack_o);
    end
    tick();
    rst = 1'b0;
    s_ack_i = 1'b0;
    #4;
    checks++;
    if (grant_o !== '0 || s_cyc_o !== 1'b0 || m_stall_o !== '1 || m_ack_o !== '0) begin
      failures++;
      $display("FAIL rstmb_reset grant=%b cyc=%b stall=%b ack=%b exp 000/0/111/000", grant_o, s_cyc_o, m_stall_o, m_ack_o);
    end
    tick(); #4;
    checks++;
    if (grant_o !== 3'b001) begin
      failures++;
      $display("FAIL rstmb_first grant=%b exp 001", grant_o);
    end
  endtask

  task automatic test_random();
    int mo = -1, mlast = N - 1, mcnt = 0;
    bit mab = 0, mfirst = 0, found;
    logic [N-1:0] eg, ea, ee, es;
    logic ecyc, estb;
    int j;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) m_cyc_i[i] = ~m_cyc_i[i];
        m_stb_i[i] = 1'($urandom_range(0, 1));
        m_we_i[i]  = 1'($urandom_range(0, 1));
        m_adr_i[i*30 +: 30] = 30'($urandom);
        m_dat_i[i*32 +: 32] = $urandom;
        m_sel_i[i*4 +: 4]   = 4'($urandom);
      end
      if (((c / 250) % 2) == 1) begin
        s_ack_i = 1'b0; s_err_i = 1'b0;
      end else begin
        s_ack_i = ($urandom_range(0, 2) == 0);
        s_err_i = ($urandom_range(0, 15) == 0);
      end
      s_stall_i = ($urandom_range(0, 3) == 0);
      s_dat_i = $urandom;
      #4;
      eg = '0; ea = '0; ee = '0; es = '1; ecyc = 1'b0; estb = 1'b0;
      if (mo >= 0) begin
        eg[mo] = 1'b1;
        if (!mab) begin
          ecyc = m_cyc_i[mo]; estb = m_stb_i[mo];
          ea[mo] = s_ack_i; ee[mo] = s_err_i; es[mo] = s_stall_i;
        end else begin
          ee[mo] = mfirst;
        end
      end
      checks++;
      if ({grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_stall_o} !== {eg, ecyc, estb, ea, ee, es}) begin
        failures++;
        $display("FAIL rand_ctrl c=%0d got g=%b cyc=%b stb=%b a=%b e=%b s=%b exp g=%b cyc=%b stb=%b a=%b e=%b s=%b",
                 c, grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_stall_o, eg, ecyc, estb, ea, ee, es);
      end
      if (mo >= 0 && !mab) begin
        checks++;
        if ({s_adr_o, s_dat_o, s_sel_o, s_we_o} !==
            {m_adr_i[mo*30 +: 30], m_dat_i[mo*32 +: 32], m_sel_i[mo*4 +: 4], m_we_i[mo]}) begin
          failures++;
          $display("FAIL rand_data c=%0d owner=%0d adr=%h dat=%h sel=%h we=%b", c, mo, s_adr_o, s_dat_o, s_sel_o, s_we_o);
        end
      end
      checks++;
      if (m_dat_o !== s_dat_i) begin
        failures++;
        $display("FAIL rand_rdata c=%0d got %h exp %h", c, m_dat_o, s_dat_i);
      end
      mfirst = 0;
      if (rst) begin
        mo = -1; mlast = N - 1; mcnt = 0; mab = 0;
      end else if (mo < 0) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          j = (mlast + k) % N;
          if (!found && m_cyc_i[j]) begin
            mo = j; found = 1;
          end
        end
        mcnt = 0; mab = 0;
      end else if (!m_cyc_i[mo]) begin
        mlast = mo; mo = -1; mab = 0;
      end else if (!mab) begin
        if (s_ack_i || s_err_i) mcnt = 0;
        else if (mcnt == TO - 1) begin
          mab = 1; mfirst = 1;
        end else mcnt++;
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_timeout();
    test_slave_err();
    test_reset_midburst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
